es8psk_frame_tx: RTL and testbench
==================================

Name: es8psk_frame_tx

Overview:
- Transmit-side framer for the es8psk link; it generates the frames that the receiver's correlator locks onto and then samples.
- Each frame is a fixed preamble of known 8PSK symbols, a fixed-length differentially encoded message pulled through a valid/ready handshake, and a silent guard interval.
- Outputs one 3-bit symbol index per chip, held for LENGTH_CHIP clocks, plus a chip strobe, feeding the pulse shaper/modulator.
- Frame length matches the receiver lock window: 6 + 117 + 7 = 130 chips.

Parameters:
- LENGTH_CHIP, 10, clocks per chip (>=2).
- LENGTH_PREAMBLE, 6, preamble chips.
- LENGTH_MESSAGE, 117, message chips per frame.
- LENGTH_GUARD, 7, guard chips (>=1).
- PREAMBLE, 18'o316025, preamble symbols, 3 bits per chip; chip 0 = bits [2:0].

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- data  in  3  message symbol.
- data_valid  in  1  data is valid.
- data_ready  out  1  one-cycle fetch request for the next message chip.
- symb  out  3  current 8PSK symbol index.
- symb_en  out  1  high while transmitting preamble/message; low in IDLE/GUARD, where the modulator outputs zero.
- chip_strobe  out  1  one-cycle pulse on the first clock of each preamble/message chip.
- busy  out  1  high from the first preamble clock through the last guard clock.
- frame_start  out  1  one-cycle pulse coincident with the first preamble chip_strobe.
- frame_end  out  1  one-cycle pulse on the last guard clock.
- underrun  out  1  one-cycle pulse when a fetch finds data_valid low.

Behaviour:
- Sync reset, effective on the next clk edge, including mid-frame.
  - All outputs go to 0; state to IDLE; counters and phase accumulator to 0.
  - A partial frame is abandoned, with no frame_end.
- FSM states: IDLE -> PREAMBLE -> MESSAGE -> GUARD -> IDLE.
- Counters:
  - cnt_samp counts 0..LENGTH_CHIP-1 and wraps.
  - cnt_chip counts chips within the current state.
  - A chip boundary is the wrap of cnt_samp.
- IDLE:
  - symb=0, symb_en=0, busy=0.
  - start=1 at edge T moves to PREAMBLE.
  - At T+1 (registered outputs): busy=1, symb_en=1, chip_strobe=1, frame_start=1, symb=PREAMBLE[2:0], phase_acc=0.
- PREAMBLE:
  - Chip k outputs PREAMBLE[3k+2:3k] raw, with no differential encoding.
  - After chip LENGTH_PREAMBLE-1, move to MESSAGE.
- MESSAGE, fetch handshake:
  - data_ready is asserted, combinationally from the counters, in the last clock of the chip preceding each message chip. This covers the last preamble chip and message chips 0..LENGTH_MESSAGE-2.
  - Exactly LENGTH_MESSAGE data_ready pulses occur per frame.
  - A transfer happens when data_ready & data_valid.
  - data_valid low during data_ready: the fetched symbol is 0, underrun pulses in the same cycle, and the frame continues unchanged.
  - data_valid outside data_ready is ignored and nothing is consumed.
- MESSAGE, differential encoding:
  - On each message chip boundary, phase_acc <= (phase_acc + d) mod 8, using 3-bit wraparound, where d is the fetched symbol (0 on underrun).
  - symb = new phase_acc, held for the whole chip.
- MESSAGE, exit: after LENGTH_MESSAGE chips, move to GUARD.
- GUARD:
  - symb=0, symb_en=0, chip_strobe=0, busy=1, no data_ready.
  - LENGTH_GUARD*LENGTH_CHIP clocks long.
  - frame_end pulses on its last clock; IDLE follows on the next edge.
- start while busy is ignored and not queued.
- Minimum spacing between frames: frame_start pulses are at least (LENGTH_PREAMBLE + LENGTH_MESSAGE + LENGTH_GUARD)*LENGTH_CHIP + 1 clocks apart.
- Output symb and symb_en change only at chip boundaries or at reset.

Test Plan:
- Single frame, data_valid always high, data=1 constant:
  - busy high for exactly 1300 clocks.
  - 123 chip_strobes spaced 10 clocks apart.
  - Preamble symbs 5,2,0,6,1,3.
  - Message symbs 1,2,3,...,7,0,1,... (wraparound).
  - frame_end on clock 1300; 117 data_ready pulses.
- Underrun: drop data_valid on the 3rd data_ready with data=2 elsewhere:
  - underrun pulses once at that cycle.
  - Message symbs 2,4,4,6,...
  - Frame timing unchanged.
- start held high continuously:
  - Frames start 1301 clocks apart.
  - start during busy produces no extra frame_start.
- Reset asserted mid-message (chip 40):
  - Next clock: all outputs 0, state IDLE, no frame_end.
  - A following start yields a clean frame with phase_acc=0.
- data_valid toggled outside data_ready windows:
  - Only values present at data_ready cycles are consumed.
  - symb sequence matches the model fed those values.
- LENGTH_CHIP=2, LENGTH_MESSAGE=1, LENGTH_GUARD=1:
  - busy lasts 16 clocks.
  - Exactly one data_ready, in clock 12 of the preamble.
  - frame_end on clock 16.

Source files
------------

// File: rtl/es8psk_frame_tx.sv
// es8psk transmit framer: raw preamble, differentially encoded message fetched
// over a valid/ready handshake, then a silent guard; one symbol per chip.
//
// state      | meaning
// S_IDLE     | waiting for start, outputs quiet
// S_PREAMBLE | sending fixed preamble symbols raw
// S_MESSAGE  | sending phase_acc, accumulated from fetched symbols
// S_GUARD    | silent guard interval, busy still high
module es8psk_frame_tx #(
    parameter int LENGTH_CHIP     = 10,
    parameter int LENGTH_PREAMBLE = 6,
    parameter int LENGTH_MESSAGE  = 117,
    parameter int LENGTH_GUARD    = 7,
    parameter logic [3*LENGTH_PREAMBLE-1:0] PREAMBLE = 18'o316025
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [2:0] symb,
    output logic       symb_en,
    output logic       chip_strobe,
    output logic       busy,
    output logic       frame_start,
    output logic       frame_end,
    output logic       underrun
);

    localparam int CHIP_MAX_PM = (LENGTH_PREAMBLE > LENGTH_MESSAGE) ? LENGTH_PREAMBLE : LENGTH_MESSAGE;
    localparam int CHIP_MAX    = (CHIP_MAX_PM > LENGTH_GUARD) ? CHIP_MAX_PM : LENGTH_GUARD;
    localparam int SAMP_W      = $clog2(LENGTH_CHIP);
    localparam int CHIP_W      = $clog2(CHIP_MAX + 1);

    localparam logic [SAMP_W-1:0] SAMP_LAST  = SAMP_W'(LENGTH_CHIP - 1);
    localparam logic [CHIP_W-1:0] PRE_LAST   = CHIP_W'(LENGTH_PREAMBLE - 1);
    localparam logic [CHIP_W-1:0] MSG_LAST   = CHIP_W'(LENGTH_MESSAGE - 1);
    localparam logic [CHIP_W-1:0] GUARD_LAST = CHIP_W'(LENGTH_GUARD - 1);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_MESSAGE, S_GUARD} state_t;

    state_t            state, state_nxt;
    logic [SAMP_W-1:0] cnt_samp;
    logic [CHIP_W-1:0] cnt_chip;
    logic [2:0]        phase_acc;
    logic              samp_last;
    logic              chip_last;

    assign samp_last = (cnt_samp == SAMP_LAST);

    always_comb begin
        chip_last = 1'b0;
        case (state)
            S_PREAMBLE: chip_last = (cnt_chip == PRE_LAST);
            S_MESSAGE:  chip_last = (cnt_chip == MSG_LAST);
            S_GUARD:    chip_last = (cnt_chip == GUARD_LAST);
            default:    chip_last = 1'b0;
        endcase
    end

    // Fetch on the last clock of the chip before each message chip, so the
    // accumulator updates exactly on that message chip's boundary.
    always_comb begin
        data_ready = 1'b0;
        if (samp_last) begin
            if (state == S_PREAMBLE && cnt_chip == PRE_LAST)
                data_ready = 1'b1;
            else if (state == S_MESSAGE && cnt_chip != MSG_LAST)
                data_ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt_samp  <= '0;
            cnt_chip  <= '0;
            phase_acc <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                cnt_samp  <= '0;
                cnt_chip  <= '0;
                phase_acc <= '0;
            end else begin
                cnt_samp <= samp_last ? '0 : cnt_samp + 1'b1;
                if (samp_last)
                    cnt_chip <= chip_last ? '0 : cnt_chip + 1'b1;
                if (data_ready)
                    phase_acc <= phase_acc + (data_valid ? data : 3'd0);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start)                  state_nxt = S_PREAMBLE;
            S_PREAMBLE: if (samp_last && chip_last) state_nxt = S_MESSAGE;
            S_MESSAGE:  if (samp_last && chip_last) state_nxt = S_GUARD;
            S_GUARD:    if (samp_last && chip_last) state_nxt = S_IDLE;
            default:                                state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        symb        = 3'd0;
        symb_en     = 1'b0;
        busy        = (state != S_IDLE);
        chip_strobe = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        underrun    = data_ready && !data_valid;
        case (state)
            S_PREAMBLE: begin
                symb        = PREAMBLE[3*int'(cnt_chip) +: 3];
                symb_en     = 1'b1;
                chip_strobe = (cnt_samp == '0);
                frame_start = (cnt_samp == '0) && (cnt_chip == '0);
            end
            S_MESSAGE: begin
                symb        = phase_acc;
                symb_en     = 1'b1;
                chip_strobe = (cnt_samp == '0);
            end
            S_GUARD: frame_end = samp_last && chip_last;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_es8psk_frame_tx.sv
// Randomized bench for es8psk_frame_tx: per-clock frame model built from chip
// arithmetic, plus a second instance with minimum-size parameters.
module tb_es8psk_frame_tx;

    localparam int LC = 10;
    localparam int LP = 6;
    localparam int LM = 117;
    localparam int LG = 7;
    localparam int FR_CLK = (LP + LM + LG) * LC;
    localparam logic [17:0] PRE = 18'o316025;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [2:0] data = '0;
    logic data_valid = 1'b0;
    logic data_ready, symb_en, chip_strobe, busy, frame_start, frame_end, underrun;
    logic [2:0] symb;

    logic s_start = 1'b0;
    logic [2:0] s_data = 3'd3;
    logic s_valid = 1'b1;
    logic s_ready, s_symb_en, s_strobe, s_busy, s_fstart, s_fend, s_under;
    logic [2:0] s_symb;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    es8psk_frame_tx dut (
        .clk(clk), .reset(reset), .start(start), .data(data), .data_valid(data_valid),
        .data_ready(data_ready), .symb(symb), .symb_en(symb_en), .chip_strobe(chip_strobe),
        .busy(busy), .frame_start(frame_start), .frame_end(frame_end), .underrun(underrun)
    );

    es8psk_frame_tx #(.LENGTH_CHIP(2), .LENGTH_PREAMBLE(6), .LENGTH_MESSAGE(1),
                      .LENGTH_GUARD(1), .PREAMBLE(18'o316025)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .data(s_data), .data_valid(s_valid),
        .data_ready(s_ready), .symb(s_symb), .symb_en(s_symb_en), .chip_strobe(s_strobe),
        .busy(s_busy), .frame_start(s_fstart), .frame_end(s_fend), .underrun(s_under)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int outv();
        return int'({busy, symb_en, chip_strobe, frame_start, frame_end, data_ready, underrun, symb});
    endfunction

    // mode 0: data=1 always valid; 1: data=2, valid dropped on 3rd fetch; 2: random
    task automatic run_frame(input int mode, input int abort_at);
        int q[$];
        int c, s, dr_i, sum, sym, n_strobe, n_dr, n_under;
        logic dr, en;
        logic [9:0] expv;
        dr_i = 0; n_strobe = 0; n_dr = 0; n_under = 0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= FR_CLK; n++) begin
            @(negedge clk);
            start = 1'b0;
            c  = (n - 1) / LC;
            s  = (n - 1) % LC;
            dr = (s == LC - 1) && (c >= LP - 1) && (c <= LP + LM - 2);
            case (mode)
                0: begin data = 3'd1; data_valid = 1'b1; end
                1: begin data = 3'd2; data_valid = !(dr && dr_i == 2); end
                default: begin
                    data = 3'($urandom_range(0, 7));
                    data_valid = 1'($urandom_range(0, 1));
                end
            endcase
            #1;
            if (c < LP) sym = int'((PRE >> (3 * c)) & 18'd7);
            else if (c < LP + LM) begin
                sum = 0;
                for (int j = 0; j <= c - LP; j++) sum += q[j];
                sym = sum % 8;
            end else sym = 0;
            en = (c < LP + LM);
            expv = {1'b1, en, en && s == 0, n == 1, n == FR_CLK, dr, dr && !data_valid, 3'(sym)};
            check($sformatf("frame m%0d n%0d", mode, n), outv(), int'(expv));
            if (chip_strobe) n_strobe++;
            if (data_ready) n_dr++;
            if (underrun) n_under++;
            if (dr) begin
                q.push_back(data_valid ? int'(data) : 0);
                dr_i++;
            end
            if (n == abort_at) begin
                reset = 1'b1;
                return;
            end
        end
        check("strobe_count", n_strobe, LP + LM);
        check("ready_count", n_dr, LM);
        if (mode == 0) check("underrun_count0", n_under, 0);
        if (mode == 1) check("underrun_count1", n_under, 1);
        @(negedge clk);
        #1;
        check("idle_after_frame", outv(), 0);
    endtask

    initial begin
        int t_fs[$];
        int n_fe, n_busy, s_busy_cnt, s_dr_cnt, s_dr_at, s_fe_at;

        repeat (3) @(negedge clk);
        #1;
        check("reset_state", outv(), 0);
        check("reset_state_s", int'({s_busy, s_symb_en, s_strobe, s_fstart, s_fend, s_ready, s_symb}), 0);
        reset = 1'b0;

        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(2, 0);

        // start held high: frames must be 1301 clocks apart
        @(negedge clk);
        start = 1'b1;
        data_valid = 1'b1;
        for (int n = 1; n <= 2800; n++) begin
            @(negedge clk);
            if (frame_start) t_fs.push_back(n);
        end
        start = 1'b0;
        repeat (1400) @(negedge clk);
        check("hold_fs_count", t_fs.size(), 3);
        if (t_fs.size() == 3) begin
            check("hold_spacing1", t_fs[1] - t_fs[0], FR_CLK + 1);
            check("hold_spacing2", t_fs[2] - t_fs[1], FR_CLK + 1);
        end

        // reset in the middle of message chip 40
        run_frame(2, (LP + 40) * LC + 4);
        @(negedge clk);
        #1;
        check("midreset_out", outv(), 0);
        reset = 1'b0;
        n_fe = 0; n_busy = 0;
        for (int n = 0; n < 1400; n++) begin
            @(negedge clk);
            #1;
            if (frame_end) n_fe++;
            if (busy) n_busy++;
        end
        check("midreset_no_frame_end", n_fe, 0);
        check("midreset_no_busy", n_busy, 0);
        run_frame(2, 0);

        // minimum-size instance: 16-clock frame, one fetch in clock 12
        s_busy_cnt = 0; s_dr_cnt = 0; s_dr_at = 0; s_fe_at = 0;
        @(negedge clk);
        s_start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            s_start = 1'b0;
            #1;
            if (s_busy) s_busy_cnt++;
            if (s_ready) begin s_dr_cnt++; s_dr_at = n; end
            if (s_fend) s_fe_at = n;
            if (n == 1) check("small_first_symb", int'(s_symb), 5);
            if (n == 13) check("small_msg_symb", int'(s_symb), 3);
            if (n == 15) check("small_guard_en", int'(s_symb_en), 0);
        end
        check("small_busy_len", s_busy_cnt, 16);
        check("small_ready_count", s_dr_cnt, 1);
        check("small_ready_clock", s_dr_at, 12);
        check("small_frame_end_clock", s_fe_at, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
